// File: rtl/qcore_pkg.sv
// Shared types and helpers for the wave-dispatch path.
// Contents: wave/time widths, the buffered entry payload, the output-side
// state encoding and the modular timestamp comparisons used at dispatch.
package qcore_pkg;

    localparam int unsigned WAVE_W = 168;
    localparam int unsigned TIME_W = 32;

    // One buffered wave-port instruction: register image plus release time.
    typedef struct packed {
        logic [WAVE_W-1:0] wave;
        logic [TIME_W-1:0] stamp;
    } wave_entry_t;

    // Output register occupancy.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_HOLD  = 1'b1
    } out_state_e;

    // Due when (now - stamp) is non-negative as a signed modular difference,
    // which stays correct across counter wrap for gaps below 2**(TIME_W-1).
    function automatic logic time_due(input logic [TIME_W-1:0] now,
                                      input logic [TIME_W-1:0] stamp);
        logic [TIME_W-1:0] diff;
        diff = now - stamp;
        return ~diff[TIME_W-1];
    endfunction

    // Late when the modular difference is strictly positive.
    function automatic logic time_late(input logic [TIME_W-1:0] now,
                                       input logic [TIME_W-1:0] stamp);
        logic [TIME_W-1:0] diff;
        diff = now - stamp;
        return ~diff[TIME_W-1] && (diff != '0);
    endfunction

endpackage

// File: rtl/qcore_sync_fifo.sv
// Synchronous FIFO with registered full/empty/count and synchronous clear.
// Ports:
//   clk, rst (sync, active high), clear (sync flush)
//   push/wdata   write at tail (caller guarantees not full unless popping)
//   pop/rdata    head word is visible combinationally on rdata
//   full, empty, count  registered status, updated the cycle after push/pop
module qcore_sync_fifo #(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_d;

    assign rdata = mem[rd_ptr];

    // Storage; a write coinciding with reset or clear is discarded.
    always_ff @(posedge clk) begin
        if (push && !rst && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count;
        unique case ({push, pop})
            2'b10:   count_d = count + (AW+1)'(1);
            2'b01:   count_d = count - (AW+1)'(1);
            default: count_d = count;
        endcase
    end

    // Pointers and registered status.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_d;
            full  <= (count_d == (AW+1)'(DEPTH));
            empty <= (count_d == '0);
        end
    end

endmodule

// File: rtl/qcore_wave_dispatch.sv
// Timed wave-output queue: buffers {wave image, out time} on each wave-port
// instruction and releases entries to the signal-generator stream once the
// reference time reaches their timestamp.
// Optional feature macro: QCORE_WAVE_LATE_CNT_EN (saturating late counter on
// late_cnt_o; when undefined late_cnt_o is tied to zero).
// Ports:
//   clk_i, rst_i (sync, active high), halt_i (blocks pushes), clear_i (flush)
//   push_i, wreg_dt_i, out_time_i   entry capture
//   time_now_i                      reference time
//   full_o, fifo_cnt_o              registered FIFO status
//   m_valid_o, m_ready_i, m_data_o, m_time_o   output stream
//   overflow_o, late_o, late_cnt_o  sticky error reporting
module qcore_wave_dispatch
    import qcore_pkg::*;
#(
    parameter int unsigned FIFO_AW = 3,
    parameter int unsigned LATE_CW = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                halt_i,
    input  logic                clear_i,
    input  logic                push_i,
    input  logic [WAVE_W-1:0]   wreg_dt_i,
    input  logic [TIME_W-1:0]   out_time_i,
    input  logic [TIME_W-1:0]   time_now_i,
    output logic                full_o,
    output logic [FIFO_AW:0]    fifo_cnt_o,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic [WAVE_W-1:0]   m_data_o,
    output logic [TIME_W-1:0]   m_time_o,
    output logic                overflow_o,
    output logic                late_o,
    output logic [LATE_CW-1:0]  late_cnt_o
);

    wave_entry_t push_entry;
    wave_entry_t head_entry;
    logic        fifo_empty;
    logic        head_ready;
    logic        head_late;
    logic        pop;
    logic        push_ok;
    logic        push_drop;
    out_state_e  state_q;
    out_state_e  state_d;

    assign push_entry = '{wave: wreg_dt_i, stamp: out_time_i};

    // Head is eligible once stored (never in its own push cycle) and due.
    assign head_ready = ~fifo_empty & time_due(time_now_i, head_entry.stamp);
    assign head_late  = time_late(time_now_i, head_entry.stamp);

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok   = push_i & ~halt_i & ~clear_i & (~full_o | pop);
    assign push_drop = push_i & ~halt_i & full_o & ~pop;

    qcore_sync_fifo #(
        .W  ($bits(wave_entry_t)),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (clear_i),
        .push  (push_ok),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head_entry),
        .full  (full_o),
        .empty (fifo_empty),
        .count (fifo_cnt_o)
    );

    // Output-side state register.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Pop decision and output-side next state.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            OUT_EMPTY: begin
                pop = head_ready;
                if (pop) begin
                    state_d = OUT_HOLD;
                end
            end
            OUT_HOLD: begin
                pop = head_ready & m_ready_i;
                if (m_ready_i && !pop) begin
                    state_d = OUT_EMPTY;
                end
            end
            default: begin
                state_d = OUT_EMPTY;
            end
        endcase
    end

    assign m_valid_o = (state_q == OUT_HOLD);

    // Output register; only a pop replaces the presented word.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            m_data_o <= '0;
            m_time_o <= '0;
        end else if (pop) begin
            m_data_o <= head_entry.wave;
            m_time_o <= head_entry.stamp;
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            overflow_o <= 1'b0;
            late_o     <= 1'b0;
        end else begin
            if (push_drop) begin
                overflow_o <= 1'b1;
            end
            if (pop && head_late) begin
                late_o <= 1'b1;
            end
        end
    end

`ifdef QCORE_WAVE_LATE_CNT_EN
    logic [LATE_CW-1:0] late_cnt_q;

    // Saturating count of late releases.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            late_cnt_q <= '0;
        end else if (pop && head_late && (late_cnt_q != '1)) begin
            late_cnt_q <= late_cnt_q + LATE_CW'(1);
        end
    end

    assign late_cnt_o = late_cnt_q;
`else
    assign late_cnt_o = '0;
`endif

endmodule

// File: doc/qcore_wave_dispatch.md
# qcore_wave_dispatch

Timed wave-output queue sitting directly downstream of the core register bank. On each wave-port instruction it captures the assembled 168-bit wave register image plus the 32-bit output time (the bank's OUT TIME special register), buffers them in a small FIFO, and releases each entry to the signal-generator stream interface once the reference time counter reaches its timestamp. It decouples instruction issue from real-time playback and reports overflow and late-dispatch errors to the core status word.

## Interface
Parameters:
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries.
- LATE_CW, 16, width of the late-event counter (only with the macro).

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous, active-high reset.
- halt_i  in  1  core halt; blocks push acceptance only.
- clear_i  in  1  synchronous flush of all state.
- push_i  in  1  wave-port instruction issue, one entry per high cycle.
- wreg_dt_i  in  168  wave register image at push.
- out_time_i  in  32  dispatch timestamp at push.
- time_now_i  in  32  free-running reference time.
- full_o  out  1  FIFO holds 2**FIFO_AW entries.
- fifo_cnt_o  out  FIFO_AW+1  occupancy.
- m_valid_o  out  1  output stream valid.
- m_ready_i  in  1  output stream ready.
- m_data_o  out  168  wave word.
- m_time_o  out  32  timestamp of the presented word.
- overflow_o  out  1  sticky: push dropped.
- late_o  out  1  sticky: entry released after its timestamp.
- late_cnt_o  out  LATE_CW  saturating late count (macro only).

## Operation
- Push accepted when push_i & ~halt_i & (~full_o | pop this cycle); entry {wreg_dt_i, out_time_i} written at tail.
- Push with full_o high and no pop in the same cycle: entry dropped, overflow_o set.
- Head is due when $signed(time_now_i - head_time) >= 0 (32-bit modular difference; correct across time wrap for gaps < 2**31).
- Pop: FIFO non-empty, head due, and output register empty or being consumed (m_valid_o & m_ready_i). Popped entry loads the output register.
- Late: at pop, if $signed(time_now_i - head_time) > 0, late_o set and late counter incremented.
- Output register holds m_data_o/m_time_o stable while m_valid_o & ~m_ready_i.
- Simultaneous push and pop: occupancy unchanged; an entry pushed into an empty FIFO is not poppable in the same cycle.
- clear_i or rst_i: pointers, occupancy, output register, m_valid_o, overflow_o, late_o, late counter cleared; in-flight push dropped. rst_i has priority over clear_i.
- Output-side states: EMPTY (m_valid_o=0), HOLD (m_valid_o=1). EMPTY→HOLD on pop; HOLD→EMPTY on handshake without pop; HOLD→HOLD on handshake with pop (back-to-back, one word per cycle).

## Timing
- Reset values: m_valid_o=0, m_data_o=0, m_time_o=0, full_o=0, fifo_cnt_o=0, overflow_o=0, late_o=0, late_cnt_o=0.
- Push at cycle N into empty FIFO with due timestamp: pop at N+1, m_valid_o high at N+2.
- Not-yet-due entry: pop in the first cycle where time_now_i equals its timestamp; m_valid_o the next cycle; no late flag.
- full_o, fifo_cnt_o registered, updated the cycle after the push/pop.
- Sticky flags assert the cycle after the causing event.

## Configuration
- QCORE_WAVE_LATE_CNT_EN defined: LATE_CW-bit saturating late counter instantiated, driven on late_cnt_o; saturates at all-ones.
- Undefined: no counter logic; late_cnt_o tied to 0; late_o still present.

## Structure
- Shared package qcore_pkg: localparam WAVE_W=168, TIME_W=32, and typedef wave_entry_t {wave[167:0], time[31:0]}.
- One sub-module qcore_sync_fifo (synchronous FIFO, parameterised width/depth, push/pop/full/empty/count, sync clear); dispatch logic and output register in the top.

## Test plan
- Reset then push {wave=168'hA5.., time=100} with time_now_i=90 → m_valid_o rises at time_now_i=101 cycle, m_time_o=100, late_o=0.
- Push 8 entries (FIFO_AW=3) with far-future time, then 9th push → full_o=1, fifo_cnt_o=8, overflow_o=1, ninth entry never output.
- Entries at times 10,11,12, time_now_i=20, m_ready_i=1 → three words on consecutive cycles, late_o=1, late_cnt_o=3.
- time_now_i=32'hFFFF_FFF0, push time=32'h0000_0005 → not released until time_now_i wraps to 5.
- m_ready_i=0 for 5 cycles with valid word → m_data_o stable, second due entry stays in FIFO; release m_ready_i → both delivered back-to-back.
- push_i with halt_i=1 → no entry; clear_i mid-stream with m_valid_o=1 → next cycle m_valid_o=0, fifo_cnt_o=0, flags 0.
